// File: rtl/e203_simd_sat_pipe_if.sv
// rtl/e203_simd_sat_pipe_if.sv - handshake and control bundle for the SIMD clip/saturation stage
//
// Purpose: groups the input beat, output beat and overflow control signals.
// Ports (all signals):
//   i_valid/i_ready  input beat handshake
//   i_op, i_ew, i_imm, i_uns, i_itag  packed elements, element width, clip exponent, unsigned mode, tag
//   o_valid/o_ready  output beat handshake
//   o_res, o_lane_ov, o_itag  clipped elements, per-byte overflow, tag
//   flush, ov_clr, ov_sticky  pipeline kill, sticky clear, sticky overflow
// Modports: master drives beats in and accepts results, slave is the clip stage.
interface e203_simd_sat_pipe_if #(
   parameter int DW     = 32,
   parameter int ITAG_W = 2
);
   logic              i_valid;
   logic              i_ready;
   logic [DW-1:0]     i_op;
   logic [1:0]        i_ew;
   logic [5:0]        i_imm;
   logic              i_uns;
   logic [ITAG_W-1:0] i_itag;
   logic              o_valid;
   logic              o_ready;
   logic [DW-1:0]     o_res;
   logic [DW/8-1:0]   o_lane_ov;
   logic [ITAG_W-1:0] o_itag;
   logic              flush;
   logic              ov_clr;
   logic              ov_sticky;

   modport master (
      output i_valid, i_op, i_ew, i_imm, i_uns, i_itag, o_ready, flush, ov_clr,
      input  i_ready, o_valid, o_res, o_lane_ov, o_itag, ov_sticky
   );

   modport slave (
      input  i_valid, i_op, i_ew, i_imm, i_uns, i_itag, o_ready, flush, ov_clr,
      output i_ready, o_valid, o_res, o_lane_ov, o_itag, ov_sticky
   );
endinterface

// File: rtl/e203_simd_sat_pipe.sv
// rtl/e203_simd_sat_pipe.sv - pipelined SIMD clip/saturation unit with sticky overflow
//
// Purpose: clips DW/8 byte lanes grouped into 8/16/32(/64)-bit signed elements to a
// programmable signed or unsigned range [lo, 2^k-1], k = min(imm, E-1), and registers
// the result in one valid/ready stage.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    e203_simd_sat_pipe_if.slave: input beat, output beat, flush, ov_clr, ov_sticky
module e203_simd_sat_pipe #(
   parameter int DW     = 32,
   parameter int ITAG_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   e203_simd_sat_pipe_if.slave   bus
);
   localparam int NB = DW / 8;

   // k = min(imm, E-1)
   function automatic logic [6:0] eff_k(input logic [6:0] e, input logic [5:0] imm);
      return ({1'b0, imm} > (e - 7'd1)) ? (e - 7'd1) : {1'b0, imm};
   endfunction

   function automatic logic signed [65:0] hi_bound(input logic [6:0] k);
      return (66'sd1 <<< k) - 66'sd1;
   endfunction

   function automatic logic signed [65:0] lo_bound(input logic [6:0] k, input logic uns);
      return uns ? 66'sd0 : -(66'sd1 <<< k);
   endfunction

   // Elements arrive sign-extended to 64 bits; the 66-bit compare keeps 2^63-1 bounds exact.
   function automatic logic clip_ov(input logic signed [63:0] x, input logic [6:0] e,
                                    input logic [5:0] imm, input logic uns);
      logic [6:0]        k;
      logic signed [65:0] xw;
      k  = eff_k(e, imm);
      xw = 66'(x);
      return (xw > hi_bound(k)) || (xw < lo_bound(k, uns));
   endfunction

   function automatic logic [63:0] clip_val(input logic signed [63:0] x, input logic [6:0] e,
                                            input logic [5:0] imm, input logic uns);
      logic [6:0]         k;
      logic signed [65:0] xw;
      logic signed [65:0] hi;
      logic signed [65:0] lo;
      logic signed [65:0] r;
      k  = eff_k(e, imm);
      xw = 66'(x);
      hi = hi_bound(k);
      lo = lo_bound(k, uns);
      if (xw > hi) begin
         r = hi;
      end else if (xw < lo) begin
         r = lo;
      end else begin
         r = xw;
      end
      return r[63:0];
   endfunction

   logic [1:0]        eff_ew;
   logic [DW-1:0]     res_c;
   logic [NB-1:0]     lov_c;
   logic [DW-1:0]     res_e3;
   logic              ov_e3;
   logic              accept;

   logic              valid_q, valid_d;
   logic [DW-1:0]     res_q, res_d;
   logic [NB-1:0]     lov_q, lov_d;
   logic [ITAG_W-1:0] itag_q, itag_d;
   logic              sticky_q, sticky_d;

   // 64-bit elements only exist on the wide datapath; on DW=32 code 3 folds to 32-bit.
   if (DW == 64) begin : g_e64
      assign res_e3 = clip_val($signed(bus.i_op[63:0]), 7'd64, bus.i_imm, bus.i_uns);
      assign ov_e3  = clip_ov($signed(bus.i_op[63:0]), 7'd64, bus.i_imm, bus.i_uns);
      assign eff_ew = bus.i_ew;
   end else begin : g_e32
      assign res_e3 = '0;
      assign ov_e3  = 1'b0;
      assign eff_ew = (bus.i_ew == 2'd3) ? 2'd2 : bus.i_ew;
   end

   always_comb begin
      res_c = '0;
      lov_c = '0;
      case (eff_ew)
         2'd0: begin
            for (int i = 0; i < NB; i++) begin
               res_c[i*8 +: 8] = 8'(clip_val(64'($signed(bus.i_op[i*8 +: 8])), 7'd8,
                                             bus.i_imm, bus.i_uns));
               lov_c[i]        = clip_ov(64'($signed(bus.i_op[i*8 +: 8])), 7'd8,
                                         bus.i_imm, bus.i_uns);
            end
         end
         2'd1: begin
            for (int i = 0; i < NB / 2; i++) begin
               res_c[i*16 +: 16] = 16'(clip_val(64'($signed(bus.i_op[i*16 +: 16])), 7'd16,
                                                bus.i_imm, bus.i_uns));
               lov_c[i*2 +: 2]   = {2{clip_ov(64'($signed(bus.i_op[i*16 +: 16])), 7'd16,
                                              bus.i_imm, bus.i_uns)}};
            end
         end
         2'd2: begin
            for (int i = 0; i < NB / 4; i++) begin
               res_c[i*32 +: 32] = 32'(clip_val(64'($signed(bus.i_op[i*32 +: 32])), 7'd32,
                                                bus.i_imm, bus.i_uns));
               lov_c[i*4 +: 4]   = {4{clip_ov(64'($signed(bus.i_op[i*32 +: 32])), 7'd32,
                                              bus.i_imm, bus.i_uns)}};
            end
         end
         default: begin
            res_c = res_e3;
            lov_c = {NB{ov_e3}};
         end
      endcase
   end

   // i_ready never depends on i_valid, so no combinational loop through the producer.
   assign bus.i_ready = ~bus.flush & (~valid_q | bus.o_ready);
   assign accept      = bus.i_valid & bus.i_ready;

   always_comb begin
      valid_d  = valid_q;
      res_d    = res_q;
      lov_d    = lov_q;
      itag_d   = itag_q;
      sticky_d = sticky_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (bus.o_ready) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         res_d  = res_c;
         lov_d  = lov_c;
         itag_d = bus.i_itag;
      end
      // A flushed result is discarded before it can report overflow; set beats clear.
      if (valid_q & bus.o_ready & ~bus.flush & (|lov_q)) begin
         sticky_d = 1'b1;
      end else if (bus.ov_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         res_q    <= '0;
         lov_q    <= '0;
         itag_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         res_q    <= res_d;
         lov_q    <= lov_d;
         itag_q   <= itag_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.o_valid   = valid_q;
   assign bus.o_res     = res_q;
   assign bus.o_lane_ov = lov_q;
   assign bus.o_itag    = itag_q;
   assign bus.ov_sticky = sticky_q;
endmodule

// File: doc/e203_simd_sat_pipe.md
# e203_simd_sat_pipe

Parametrised, pipelined SIMD clip/saturation unit for the E203 DSP datapath. It packs DW/8 byte lanes and supports element widths 8, 16 and 32, plus 64 when DW=64. Each element is clipped to a programmable signed or unsigned range, with a per-lane overflow flag and a sticky overflow bit (OV, vxsat-style). It sits after the EXU operand mux, talks valid/ready on both sides, and adds one register stage.

## Interface
- DW, default 32: datapath width. Legal values are 32 and 64.
- ITAG_W, default 2: width of the instruction tag carried through the stage.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid & i_ready.
- i_op  in  DW  packed elements.
- i_ew  in  2  element width: 0=8, 1=16, 2=32, 3=64. Code 3 is legal only when DW=64; with DW=32 it is treated as 32.
- i_imm  in  6  clip bound exponent.
- i_uns  in  1  0 selects signed clip, 1 selects unsigned clip.
- i_itag  in  ITAG_W  tag.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accept.
- o_res  out  DW  clipped elements.
- o_lane_ov  out  DW/8  per-byte overflow. An element's flag is replicated on all of its bytes.
- o_itag  out  ITAG_W  tag of the result.
- flush  in  1  pipeline kill.
- ov_clr  in  1  clears ov_sticky.
- ov_sticky  out  1  sticky overflow.

## Operation
- Element width: E = 8<<i_ew.
- Effective exponent: k = min(i_imm, E-1).
- Inputs are always interpreted as two's-complement signed elements.
- Signed clip range: [-2^k, 2^k-1].
- Unsigned clip range: [0, 2^k-1].
- If x > max, the result is max and ov=1.
- If x < min, the result is min and ov=1. In unsigned mode every negative x gives 0 with ov=1.
- Otherwise the result is x and ov=0.
- Lanes are fully independent. There is no carry or compare across element boundaries.
- Clip and overflow are computed combinationally from the input beat and registered on accept.
- ov_sticky is set on the cycle a result handshakes (o_valid & o_ready) with |o_lane_ov.
- ov_sticky is cleared by ov_clr. If set and clear occur in the same cycle, set wins.
- flush drops the staged result: o_valid=0 next cycle.
- An i_valid beat in the flush cycle is not accepted, because i_ready=0 during flush.
- A flushed result never touches ov_sticky.

## Timing
- Reset values: o_valid=0, o_res=0, o_lane_ov=0, o_itag=0, ov_sticky=0.
- Latency is exactly 1 cycle: a beat accepted at edge N shows o_valid=1 with its data after edge N.
- Throughput is 1 beat/cycle while o_ready=1.
- i_ready = ~flush & (~o_valid | o_ready). This is combinational, with no combinational path from i_valid to i_ready.
- The output register loads on i_valid & i_ready.
- o_valid clears when o_ready=1 and no new beat arrives.
- While o_valid & ~o_ready, o_res, o_lane_ov and o_itag are held stable.
- Results leave in acceptance order.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The in-flight beat is lost.
- After reset deasserts, the first accept can occur on the first clock edge.

## Test plan
- Signed byte clip: DW=32, ew=0, imm=3, uns=0, op=0x7F8005F8. Expect o_res=0x07F805F8 and o_lane_ov=4'b1100 one cycle after accept.
- Unsigned halfword clip: ew=1, imm=4, uns=1, op=0xFFFF0010. Expect o_res=0x0000000F and o_lane_ov=4'b1111.
- Bound saturation of imm: ew=2, uns=0, op=0x80000000 with imm=31 and again with imm=40. Both give o_res=0x80000000, o_lane_ov=0. Repeat with uns=1 and imm=40: o_res=0, o_lane_ov=4'b1111.
- Backpressure and ordering:
  - Send beat A.
  - Hold o_ready=0 for 3 cycles while beat B is offered.
  - Expect i_ready=0 and o_res/o_itag held at A.
  - Release o_ready: A handshakes, B is accepted the same cycle, and B appears next cycle.
  - Then stream 8 back-to-back beats at full rate.
- Sticky behaviour:
  - An overflowing result handshakes with ov_clr=1 in the same cycle: ov_sticky=1 next cycle.
  - ov_clr alone on the following cycle: ov_sticky=0.
  - A non-overflowing handshake leaves ov_sticky unchanged.
- Flush and reset:
  - With an overflowing result staged (o_ready=0), assert flush together with i_valid=1. Next cycle o_valid=0, ov_sticky unchanged, and the new beat is not accepted.
  - Separately, drop rst_n while o_valid=1. All outputs go to 0 asynchronously, and after release the first beat completes with 1-cycle latency.
- DW=64 regression: ew=3, imm=62, uns=0, op=0x7FFFFFFFFFFFFFFF. Expect o_res=0x3FFFFFFFFFFFFFFF and o_lane_ov=8'hFF.
